// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, T-state encoding,
// the strobe bundle and per-opcode sequence-length helpers.
package cpu_ctrl_pkg;

  localparam int OPW = 5;
  localparam logic [OPW-1:0] ADD_OP = 5'b00011;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_BRX  = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10011;
  localparam logic [OPW-1:0] OP_IN   = 5'b10101;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
  localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
  localparam logic [OPW-1:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    RESET_ST = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT_ST = 4'd9
  } state_e;

  typedef struct packed {
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout;
    logic PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic IncPC, Read, Write;
    logic [OPW-1:0] ALUop;
  } ctrl_t;

  // Immediate forms reuse the reg-reg ALU codes.
  function automatic logic [OPW-1:0] imm_alu(input logic [OPW-1:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

  function automatic logic is_last(input state_e s, input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: return s == T5;
      OP_LD, OP_ST:                     return s == T7;
      OP_BRX:                           return s == T6;
      default:                          return s == T3;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode: present T-state plus opcode (and CON in brx T6)
// to the full datapath control bundle.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]  state_i,
  input  logic [4:0]  op_i,
  input  logic        con_i,
  output logic [31:0] ctrl_o
);

  ctrl_t  c;
  state_e st;

  assign st     = state_e'(state_i);
  assign ctrl_o = c;

  always_comb begin
    c = '0;
    case (st)
      T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.PCin = 1'b1; end
      T1: begin c.Read = 1'b1; c.MDRin = 1'b1; end
      T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      T3: begin
        case (op_i)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI:
            begin c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
          OP_LD, OP_LDI, OP_ST:
            begin c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; end
          OP_BRX:  begin c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1; end
          OP_JR:   begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; end
          OP_IN:   begin c.InPortout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          OP_OUT:  begin c.Gra = 1'b1; c.Rout = 1'b1; c.OutPortin = 1'b1; end
          OP_MFHI: begin c.HIout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          OP_MFLO: begin c.LOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        case (op_i)
          OP_ADD, OP_SUB, OP_AND, OP_OR:
            begin c.Grc = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; c.ALUop = op_i; end
          OP_ADDI, OP_ANDI, OP_ORI:
            begin c.Cout = 1'b1; c.Zin = 1'b1; c.ALUop = imm_alu(op_i); end
          OP_LD, OP_LDI, OP_ST:
            begin c.Cout = 1'b1; c.Zin = 1'b1; c.ALUop = ADD_OP; end
          OP_BRX: begin c.PCout = 1'b1; c.Yin = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (op_i)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
            begin c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          OP_LD, OP_ST: begin c.Zlowout = 1'b1; c.MARin = 1'b1; end
          OP_BRX: begin c.Cout = 1'b1; c.Zin = 1'b1; c.ALUop = ADD_OP; end
          default: ;
        endcase
      end
      T6: begin
        case (op_i)
          OP_LD:  begin c.Read = 1'b1; c.MDRin = 1'b1; end
          OP_ST:  begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1; end
          OP_BRX: begin c.Zlowout = con_i; c.PCin = con_i; end
          default: ;
        endcase
      end
      T7: begin
        case (op_i)
          OP_LD:   begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          OP_ST:   c.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore T-state sequencer for the datapath: fetch T0-T2, decode at
// T3, per-opcode execute states, halt on opcode or latched Stop request.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] opcode,
  input  logic       CON,
  input  logic       Stop,
  output logic       PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout,
  output logic       PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin,
  output logic       Gra, Grb, Grc, Rin, Rout,
  output logic       IncPC, Read, Write,
  output logic [4:0] ALUop,
  output logic       Run
);

  state_e     state_q, state_d;
  logic [4:0] op_q;
  logic       stop_q;
  logic [4:0] op_cur;
  ctrl_t      ctrl;

  // IR becomes valid in T3; hold it from then on so later T-states are stable.
  assign op_cur = (state_q == T3) ? opcode : op_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RESET_ST;
      op_q    <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == T3) op_q <= opcode;
      if (Stop) stop_q <= 1'b1;
    end
  end

  // A Stop seen at any point is held until the instruction's last state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_ST: state_d = T0;
      T0:       state_d = T1;
      T1:       state_d = T2;
      T2:       state_d = T3;
      T3, T4, T5, T6, T7: begin
        if (state_q == T3 && op_cur == OP_HALT) state_d = HALT_ST;
        else if (is_last(state_q, op_cur))      state_d = (Stop || stop_q) ? HALT_ST : T0;
        else                                    state_d = state_e'(state_q + 4'd1);
      end
      HALT_ST:  state_d = HALT_ST;
      default:  state_d = RESET_ST;
    endcase
  end

  ctrl_decode u_decode (
    .state_i (state_q),
    .op_i    (op_cur),
    .con_i   (CON),
    .ctrl_o  (ctrl)
  );

  always_comb begin
    Run       = (state_q != HALT_ST);
    PCout     = ctrl.PCout;     Zhighout  = ctrl.Zhighout;  Zlowout = ctrl.Zlowout;
    MDRout    = ctrl.MDRout;    HIout     = ctrl.HIout;     LOout   = ctrl.LOout;
    BAout     = ctrl.BAout;     InPortout = ctrl.InPortout; Cout    = ctrl.Cout;
    PCin      = ctrl.PCin;      Zin       = ctrl.Zin;       MDRin   = ctrl.MDRin;
    MARin     = ctrl.MARin;     Yin       = ctrl.Yin;       HIin    = ctrl.HIin;
    LOin      = ctrl.LOin;      IRin      = ctrl.IRin;      OutPortin = ctrl.OutPortin;
    CONin     = ctrl.CONin;     Gra       = ctrl.Gra;       Grb     = ctrl.Grb;
    Grc       = ctrl.Grc;       Rin       = ctrl.Rin;       Rout    = ctrl.Rout;
    IncPC     = ctrl.IncPC;     Read      = ctrl.Read;      Write   = ctrl.Write;
    ALUop     = ctrl.ALUop;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: fixed vector table, hand-written halt/stop/reset
// sequences, then random instructions checked against a per-opcode step model.
module tb_control_sequencer;

  logic       Clock = 1'b0;
  logic       Reset, CON, Stop;
  logic [4:0] opcode;
  logic       PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout;
  logic       PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin;
  logic       Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, Run;
  logic [4:0] ALUop;

  always #5 Clock = ~Clock;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .opcode(opcode), .CON(CON), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .BAout(BAout), .InPortout(InPortout), .Cout(Cout),
    .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .IRin(IRin), .OutPortin(OutPortin), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .IncPC(IncPC), .Read(Read), .Write(Write), .ALUop(ALUop), .Run(Run)
  );

  logic [32:0] obs;
  logic [9:0]  bus;
  assign obs = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout,
                PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin,
                Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, ALUop, Run};
  assign bus = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout, Rout};

  localparam logic [32:0] M_PCOUT = 33'd1 << 32, M_ZLOWOUT = 33'd1 << 30,
    M_MDROUT = 33'd1 << 29, M_HIOUT = 33'd1 << 28, M_LOOUT = 33'd1 << 27,
    M_BAOUT = 33'd1 << 26, M_INPORTOUT = 33'd1 << 25, M_COUT = 33'd1 << 24,
    M_PCIN = 33'd1 << 23, M_ZIN = 33'd1 << 22, M_MDRIN = 33'd1 << 21,
    M_MARIN = 33'd1 << 20, M_YIN = 33'd1 << 19, M_IRIN = 33'd1 << 16,
    M_OUTPORTIN = 33'd1 << 15, M_CONIN = 33'd1 << 14, M_GRA = 33'd1 << 13,
    M_GRB = 33'd1 << 12, M_GRC = 33'd1 << 11, M_RIN = 33'd1 << 10,
    M_ROUT = 33'd1 << 9, M_INCPC = 33'd1 << 8, M_READ = 33'd1 << 7,
    M_WRITE = 33'd1 << 6, M_RUN = 33'd1;

  localparam logic [32:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_PCIN | M_RUN;
  localparam logic [32:0] F1 = M_READ | M_MDRIN | M_RUN;
  localparam logic [32:0] F2 = M_MDROUT | M_IRIN | M_RUN;

  function automatic logic [32:0] aluf(input logic [4:0] a);
    return {27'd0, a, 1'b0};
  endfunction

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name);
    total++;
    if ($countones(bus) > 1) begin
      bad++;
      $display("FAIL %s bus_excl: got drivers %b want at most one", name, bus);
    end
  endtask

  // Reference: the strobe set of every cycle of one instruction, T0 to its last state.
  task automatic model_instr(input logic [4:0] op, input logic con);
    logic [32:0] s[$];
    logic [4:0]  a;
    s = '{F0, F1, F2};
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        s.push_back(M_GRB | M_ROUT | M_YIN);
        s.push_back(M_GRC | M_ROUT | M_ZIN | aluf(op));
        s.push_back(M_ZLOWOUT | M_GRA | M_RIN);
      end
      5'd12, 5'd13, 5'd14: begin
        a = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
        s.push_back(M_GRB | M_ROUT | M_YIN);
        s.push_back(M_COUT | M_ZIN | aluf(a));
        s.push_back(M_ZLOWOUT | M_GRA | M_RIN);
      end
      5'd0, 5'd1, 5'd2: begin
        s.push_back(M_GRB | M_BAOUT | M_YIN);
        s.push_back(M_COUT | M_ZIN | aluf(5'd3));
        if (op == 5'd1) s.push_back(M_ZLOWOUT | M_GRA | M_RIN);
        else            s.push_back(M_ZLOWOUT | M_MARIN);
        if (op == 5'd0) begin
          s.push_back(M_READ | M_MDRIN);
          s.push_back(M_MDROUT | M_GRA | M_RIN);
        end
        if (op == 5'd2) begin
          s.push_back(M_GRA | M_ROUT | M_MDRIN);
          s.push_back(M_WRITE);
        end
      end
      5'd18: begin
        s.push_back(M_GRA | M_ROUT | M_CONIN);
        s.push_back(M_PCOUT | M_YIN);
        s.push_back(M_COUT | M_ZIN | aluf(5'd3));
        s.push_back(con ? (M_ZLOWOUT | M_PCIN) : 33'd0);
      end
      5'd19: s.push_back(M_GRA | M_ROUT | M_PCIN);
      5'd21: s.push_back(M_INPORTOUT | M_GRA | M_RIN);
      5'd22: s.push_back(M_GRA | M_ROUT | M_OUTPORTIN);
      5'd23: s.push_back(M_HIOUT | M_GRA | M_RIN);
      5'd24: s.push_back(M_LOOUT | M_GRA | M_RIN);
      default: s.push_back(33'd0);
    endcase
    foreach (s[i]) exp_q.push_back(s[i] | M_RUN);
  endtask

  // Entered and left just after a negedge with the DUT in T0.
  task automatic do_reset();
    Reset = 1'b1; Stop = 1'b0;
    @(negedge Clock); #1;
    check("reset_state", obs, M_RUN);
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic con, input int stop_cyc);
    int n;
    logic halt_exp;
    logic [32:0] e;
    opcode = op; CON = con;
    exp_q.delete();
    model_instr(op, con);
    n = exp_q.size();
    halt_exp = (op == 5'd26) || (stop_cyc >= 0 && stop_cyc < n);
    for (int i = 0; i < n; i++) begin
      Stop = (i == stop_cyc);
      #1;
      e = exp_q.pop_front();
      check($sformatf("seq op=%0d cyc=%0d", op, i), obs, e);
      check_bus($sformatf("seq op=%0d cyc=%0d", op, i));
      @(negedge Clock);
    end
    Stop = 1'b0;
    if (halt_exp) begin
      for (int k = 0; k < 3; k++) begin
        #1;
        check($sformatf("halt_hold op=%0d k=%0d", op, k), obs, 33'd0);
        @(negedge Clock);
      end
      do_reset();
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic        con;
    int          len;
    logic [32:0] t3, t4, last;
  } vec_t;

  vec_t tbl[16];

  task automatic apply_vec(input vec_t v);
    logic [32:0] fv[3];
    fv = '{F0, F1, F2};
    opcode = v.op; CON = v.con; Stop = 1'b0;
    for (int i = 0; i <= v.len; i++) begin
      #1;
      if (i < 3) check($sformatf("vec op=%0d fetch%0d", v.op, i), obs, fv[i]);
      if (i == 3) check($sformatf("vec op=%0d t3", v.op), obs, v.t3);
      if (i == 4) check($sformatf("vec op=%0d t4", v.op), obs, v.t4);
      if (i == v.len - 1) check($sformatf("vec op=%0d last", v.op), obs, v.last);
      if (i == v.len) check($sformatf("vec op=%0d back_to_t0", v.op), obs, F0);
      check($sformatf("vec op=%0d write cyc=%0d", v.op, i), {32'd0, Write},
            {32'd0, (v.op == 5'd2 && i == 7)});
      check_bus($sformatf("vec op=%0d cyc=%0d", v.op, i));
      if (i < v.len) @(negedge Clock);
    end
  endtask

  initial begin
    Reset = 1'b1; Stop = 1'b0; opcode = 5'd0; CON = 1'b0;
    tbl[0]  = '{5'd3,  1'b0, 6, M_GRB|M_ROUT|M_YIN|M_RUN, M_GRC|M_ROUT|M_ZIN|aluf(5'd3)|M_RUN, M_ZLOWOUT|M_GRA|M_RIN|M_RUN};
    tbl[1]  = '{5'd4,  1'b0, 6, M_GRB|M_ROUT|M_YIN|M_RUN, M_GRC|M_ROUT|M_ZIN|aluf(5'd4)|M_RUN, M_ZLOWOUT|M_GRA|M_RIN|M_RUN};
    tbl[2]  = '{5'd6,  1'b0, 6, M_GRB|M_ROUT|M_YIN|M_RUN, M_GRC|M_ROUT|M_ZIN|aluf(5'd6)|M_RUN, M_ZLOWOUT|M_GRA|M_RIN|M_RUN};
    tbl[3]  = '{5'd12, 1'b0, 6, M_GRB|M_ROUT|M_YIN|M_RUN, M_COUT|M_ZIN|aluf(5'd3)|M_RUN, M_ZLOWOUT|M_GRA|M_RIN|M_RUN};
    tbl[4]  = '{5'd13, 1'b0, 6, M_GRB|M_ROUT|M_YIN|M_RUN, M_COUT|M_ZIN|aluf(5'd5)|M_RUN, M_ZLOWOUT|M_GRA|M_RIN|M_RUN};
    tbl[5]  = '{5'd14, 1'b0, 6, M_GRB|M_ROUT|M_YIN|M_RUN, M_COUT|M_ZIN|aluf(5'd6)|M_RUN, M_ZLOWOUT|M_GRA|M_RIN|M_RUN};
    tbl[6]  = '{5'd0,  1'b0, 8, M_GRB|M_BAOUT|M_YIN|M_RUN, M_COUT|M_ZIN|aluf(5'd3)|M_RUN, M_MDROUT|M_GRA|M_RIN|M_RUN};
    tbl[7]  = '{5'd1,  1'b0, 6, M_GRB|M_BAOUT|M_YIN|M_RUN, M_COUT|M_ZIN|aluf(5'd3)|M_RUN, M_ZLOWOUT|M_GRA|M_RIN|M_RUN};
    tbl[8]  = '{5'd2,  1'b0, 8, M_GRB|M_BAOUT|M_YIN|M_RUN, M_COUT|M_ZIN|aluf(5'd3)|M_RUN, M_WRITE|M_RUN};
    tbl[9]  = '{5'd18, 1'b0, 7, M_GRA|M_ROUT|M_CONIN|M_RUN, M_PCOUT|M_YIN|M_RUN, M_RUN};
    tbl[10] = '{5'd18, 1'b1, 7, M_GRA|M_ROUT|M_CONIN|M_RUN, M_PCOUT|M_YIN|M_RUN, M_ZLOWOUT|M_PCIN|M_RUN};
    tbl[11] = '{5'd19, 1'b0, 4, M_GRA|M_ROUT|M_PCIN|M_RUN, F0, M_GRA|M_ROUT|M_PCIN|M_RUN};
    tbl[12] = '{5'd21, 1'b0, 4, M_INPORTOUT|M_GRA|M_RIN|M_RUN, F0, M_INPORTOUT|M_GRA|M_RIN|M_RUN};
    tbl[13] = '{5'd22, 1'b0, 4, M_GRA|M_ROUT|M_OUTPORTIN|M_RUN, F0, M_GRA|M_ROUT|M_OUTPORTIN|M_RUN};
    tbl[14] = '{5'd24, 1'b0, 4, M_LOOUT|M_GRA|M_RIN|M_RUN, F0, M_LOOUT|M_GRA|M_RIN|M_RUN};
    tbl[15] = '{5'd31, 1'b0, 4, M_RUN, F0, M_RUN};

    @(negedge Clock);
    do_reset();
    foreach (tbl[i]) apply_vec(tbl[i]);

    // halt opcode, then Stop pulsed in ld T5: ld must still complete T6/T7
    run_instr(5'd26, 1'b0, -1);
    run_instr(5'd0, 1'b0, 5);
    run_instr(5'd23, 1'b0, -1);

    // Reset landing in st T6 must suppress the T7 Write
    opcode = 5'd2; CON = 1'b0;
    repeat (6) @(negedge Clock);
    #1;
    check("st_t6_before_reset", obs, M_GRA | M_ROUT | M_MDRIN | M_RUN);
    Reset = 1'b1;
    @(negedge Clock); #1;
    check("st_reset_no_write", obs, M_RUN);
    Reset = 1'b0;
    @(negedge Clock); #1;
    check("st_reset_refetch", obs, F0);

    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      int sc;
      op = 5'($urandom_range(0, 31));
      sc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr(op, 1'($urandom_range(0, 1)), sc);
    end
    #1;
    check("final_t0", obs, F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit that sits directly upstream of `datapath`.
- Drives every datapath strobe (PCout, MARin, Read, Gra/Grb/Grc, Rin/Rout, ...), replacing hand-scripted per-instruction stimulus with a clocked T-state sequencer.
- Fetches (T0–T2), decodes the 5-bit opcode from IR[31:27], then steps through the execute states for each instruction.

Parameters:
- OPW, 5, opcode width
- ADD_OP, 5'b00011, ALU code issued for address/offset calculation

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clock
- opcode  in  5  IR[31:27]; valid from T3 onward
- CON  in  1  branch-condition flag from CON FF logic; sampled in T6 of brx
- Stop  in  1  halt request
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout  out  1 each  bus drivers
- PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin  out  1 each  register loads
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-file select/enable
- IncPC, Read, Write  out  1 each  PC increment, memory read, memory write
- ALUop  out  5  ALU operation select
- Run  out  1  high while executing; low in Halt

Behaviour:
- Moore outputs decode combinationally from the present state only. Every strobe is high for exactly one full Clock cycle.
- Reset: next state is Reset_st. All strobes are 0, ALUop=0, Run=1. Reset_st always advances to T0 one cycle later.
- Reset mid-instruction aborts the instruction. No Write or Rin may be issued in the cycle after Reset is sampled.
- Fetch, same for every instruction:
  - T0: PCout, MARin, IncPC, PCin
  - T1: Read, MDRin
  - T2: MDRout, IRin
- Execute: opcode is sampled on entry to T3. Each sequence below lists T3 onward; after its final state the sequencer returns to T0.
- ALU reg-reg: add 00011, sub 00100, and 00101, or 00110.
  - T3: Grb, Rout, Yin
  - T4: Grc, Rout, Zin, ALUop=opcode
  - T5: Zlowout, Gra, Rin
- ALU immediate: addi 01100, andi 01101, ori 01110.
  - Same as reg-reg, except T4 uses Cout in place of Grc/Rout.
  - ALUop = add/and/or respectively.
- ld 00000:
  - T3: Grb, BAout, Yin
  - T4: Cout, Zin, ALUop=ADD_OP
  - T5: Zlowout, MARin
  - T6: Read, MDRin
  - T7: MDRout, Gra, Rin
- ldi 00001: T3 and T4 as ld; T5: Zlowout, Gra, Rin.
- st 00010:
  - T3–T5 as ld
  - T6: Gra, Rout, MDRin (Read=0)
  - T7: Write
- brx 10010:
  - T3: Gra, Rout, CONin
  - T4: PCout, Yin
  - T5: Cout, Zin, ALUop=ADD_OP
  - T6: if CON=1, Zlowout, PCin; otherwise no strobes
- jr 10011: T3: Gra, Rout, PCin.
- in 10101: T3: InPortout, Gra, Rin.
- out 10110: T3: Gra, Rout, OutPortin.
- mfhi 10111: T3: HIout, Gra, Rin.
- mflo 11000: T3: LOout, Gra, Rin.
- nop 11001, and any undefined opcode: T3 has no strobes, then T0.
- halt 11010: T3 goes to Halt_st.
  - Halt_st: all strobes 0, Run=0.
  - Left only by Reset.
- Stop: if Stop=1 on the cycle the sequencer would return to T0, it enters Halt_st instead. The current instruction always completes.
- At most one bus-driver output is high in any state. This is an invariant to assert in the bench.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_LD … OP_HALT)
  - state encoding (Reset_st, T0–T7, Halt_st; 4-bit)
  - ADD_OP
- One optional sub-module, ctrl_decode: combinational state+opcode → strobe vector. The sequencer keeps only the state register and next-state logic.

Test Plan:
- Reset pulse then release → Reset_st; T0 next cycle with PCout=MARin=IncPC=PCin=1; T1 Read=MDRin=1; T2 MDRout=IRin=1.
- opcode=00011 (add) → T4 asserts Grc, Rout, Zin with ALUop=00011; T5 asserts Zlowout, Gra, Rin; cycle 6 after T0 is T0 again.
- opcode=00010 (st) → Write=1 only in T7; Write never high in any other cycle; 8 cycles per instruction.
- opcode=10010 with CON=0, then CON=1 → T6 has no strobes vs Zlowout=PCin=1; both return to T0.
- opcode=10011 (jr) → T3 asserts Gra, Rout, PCin for one cycle, then T0 (matches the 4-state jr sequence).
- opcode=11010 (halt), or Stop=1 during ld T5 → ld finishes T7, then Halt_st with Run=0 held; Reset → Reset_st, Run=1. Reset asserted in st T6 → no Write in the following cycle.
